// File: rtl/alu_serial_pkg.sv
// Shared types and codes for the bit-serial ALU sequencer.
// Holds the FSM state type plus the slice MC and MUX code names.
package alu_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] MC_ARITH = 2'b00;
    localparam logic [1:0] MC_MODE1 = 2'b01;
    localparam logic [1:0] MC_MODE2 = 2'b10;
    localparam logic [1:0] MC_LOGIC = 2'b11;

    localparam logic [3:0] FN_0 = 4'h0;
    localparam logic [3:0] FN_1 = 4'h1;
    localparam logic [3:0] FN_2 = 4'h2;
    localparam logic [3:0] FN_3 = 4'h3;
    localparam logic [3:0] FN_4 = 4'h4;
    localparam logic [3:0] FN_5 = 4'h5;
    localparam logic [3:0] FN_6 = 4'h6;
    localparam logic [3:0] FN_7 = 4'h7;
    localparam logic [3:0] FN_8 = 4'h8;
    localparam logic [3:0] FN_9 = 4'h9;
    localparam logic [3:0] FN_A = 4'hA;
    localparam logic [3:0] FN_B = 4'hB;
    localparam logic [3:0] FN_C = 4'hC;
    localparam logic [3:0] FN_D = 4'hD;
    localparam logic [3:0] FN_E = 4'hE;
    // Full add in arithmetic mode.
    localparam logic [3:0] FN_F = 4'hF;

endpackage

// File: rtl/alu_serial_bitcnt.sv
// Bit index counter for the serial sequencer.
// Ports: clk, rst_n, clr (to 0), en (+1), idx, last (idx == WIDTH-1).
module alu_serial_bitcnt #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] idx,
    output logic          last
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (en) begin
            idx <= idx + 1'b1;
        end
    end

    assign last = (idx == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial sequencer around a 1-bit ALU slice, LSB first.
// Ports: clk, rst_n, start, op_a, op_b, mc, mux, cin in; busy, done,
// result, cout, zero, ovf out; slice_a/b/cin/mc/mux to the slice and
// slice_out/slice_cout back from it. Define ALU_SERIAL_OVF_EN to get
// a real signed overflow flag on ovf; otherwise ovf is tied low.
module alu_serial_seq
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mc,
    input  logic [3:0]       mux,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             zero,
    output logic             ovf,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_cin,
    output logic [1:0]       slice_mc,
    output logic [3:0]       slice_mux,
    input  logic             slice_out,
    input  logic             slice_cout
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [1:0]       mc_lat;
    logic [3:0]       mux_lat;
    logic             carry;
    logic [CW-1:0]    idx;
    logic             last;
    logic             accept;
    logic             running;
    logic [WIDTH-1:0] res_nxt;

    assign accept  = (state == IDLE) && start;
    assign running = (state == RUN);

    alu_serial_bitcnt #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_bitcnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == IDLE),
        .en    (running),
        .idx   (idx),
        .last  (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = running;
        done      = (state == DONE);
        slice_a   = 1'b0;
        slice_b   = 1'b0;
        slice_cin = 1'b0;
        slice_mc  = 2'b00;
        slice_mux = 4'h0;
        if (running) begin
            slice_a   = a_lat[idx];
            slice_b   = b_lat[idx];
            slice_cin = carry;
            slice_mc  = mc_lat;
            slice_mux = mux_lat;
        end
    end

    // Result with the current bit merged in; zero must see the final bit.
    always_comb begin
        res_nxt      = result;
        res_nxt[idx] = slice_out;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat   <= '0;
            b_lat   <= '0;
            mc_lat  <= 2'b00;
            mux_lat <= 4'h0;
            carry   <= 1'b0;
            result  <= '0;
            cout    <= 1'b0;
            zero    <= 1'b0;
        end else if (accept) begin
            a_lat   <= op_a;
            b_lat   <= op_b;
            mc_lat  <= mc;
            mux_lat <= mux;
            carry   <= cin;
        end else if (running) begin
            result <= res_nxt;
            carry  <= slice_cout;
            if (last) begin
                cout <= slice_cout;
                zero <= (res_nxt == '0);
            end
        end
    end

`ifdef ALU_SERIAL_OVF_EN
    // Carry presented to the MSB is still in the carry flop on the
    // last bit, so it is used directly as c_msb.
    logic c_msb;
    logic ovf_q;

    assign c_msb = carry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (running && last) begin
            ovf_q <= c_msb ^ slice_cout;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_alu_serial_seq.sv
// Self-checking bench for alu_serial_seq with a behavioural 1-bit
// slice attached and a word-level reference model.
module tb_alu_serial_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [1:0]   mc = 2'b00;
    logic [3:0]   mux = 4'h0;
    logic         cin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         zero;
    logic         ovf;
    logic         slice_a;
    logic         slice_b;
    logic         slice_cin;
    logic [1:0]   slice_mc;
    logic [3:0]   slice_mux;
    logic         slice_out;
    logic         slice_cout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    alu_serial_seq #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .op_a       (op_a),
        .op_b       (op_b),
        .mc         (mc),
        .mux        (mux),
        .cin        (cin),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .cout       (cout),
        .zero       (zero),
        .ovf        (ovf),
        .slice_a    (slice_a),
        .slice_b    (slice_b),
        .slice_cin  (slice_cin),
        .slice_mc   (slice_mc),
        .slice_mux  (slice_mux),
        .slice_out  (slice_out),
        .slice_cout (slice_cout)
    );

    // Behavioural slice: mc[1] selects logic, mc=01 is increment,
    // mc=00 adds B (mux odd) or ~B (mux even) with carry.
    always_comb begin
        logic bb;
        slice_out  = 1'b0;
        slice_cout = 1'b0;
        bb         = 1'b0;
        if (slice_mc[1]) begin
            if (slice_mux == 4'h0)
                slice_out = ~slice_a;
            else if (slice_mux == 4'h8)
                slice_out = slice_a ^ slice_b;
            else
                slice_out = slice_mux[{slice_a, slice_b}];
        end else begin
            bb = slice_mc[0] ? 1'b0 :
                 (slice_mux[0] ? slice_b : ~slice_b);
            slice_out  = slice_a ^ bb ^ slice_cin;
            slice_cout = (slice_a & bb) | (slice_a & slice_cin) |
                         (bb & slice_cin);
        end
    end

    // Word-level reference: returns {ovf, cout, result}.
    function automatic logic [W+1:0] ref_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   m,
        input logic [3:0]   x,
        input logic         c
    );
        logic [W-1:0] r;
        logic [W-1:0] bb;
        logic [W:0]   s;
        logic         v;
        if (m[1]) begin
            if (x == 4'h0)
                r = ~a;
            else if (x == 4'h8)
                r = a ^ b;
            else
                r = ({W{x[3]}} & a & b) | ({W{x[2]}} & a & ~b) |
                    ({W{x[1]}} & ~a & b) | ({W{x[0]}} & ~a & ~b);
            return {2'b00, r};
        end
        if (m[0])
            bb = '0;
        else
            bb = x[0] ? b : ~b;
        s = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, c};
        v = (a[W-1] == bb[W-1]) && (s[W-1] != a[W-1]);
`ifndef ALU_SERIAL_OVF_EN
        v = 1'b0;
`endif
        return {v, s[W], s[W-1:0]};
    endfunction

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One operation with mid-run input scrambling; start is forced
    // high at bit 3 and randomly elsewhere while RUN is active.
    task automatic run_op(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   m,
        input logic [3:0]   x,
        input logic         c
    );
        logic [W+1:0] e;
        int dn;
        int bc;
        int dk;
        e = ref_op(a, b, m, x, c);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        mc    = m;
        mux   = x;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        dn = 0;
        bc = 0;
        dk = -1;
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) begin
                dn++;
                if (dk < 0) dk = k;
                chk("result", 32'(result), 32'(e[W-1:0]));
                chk("cout", 32'(cout), 32'(e[W]));
                chk("zero", 32'(zero), 32'(e[W-1:0] == '0));
                chk("ovf", 32'(ovf), 32'(e[W+1]));
            end
            if (k < W) begin
                op_a  = W'($urandom);
                op_b  = W'($urandom);
                mc    = 2'($urandom);
                mux   = 4'($urandom);
                cin   = 1'($urandom);
                start = (k == 3) ? 1'b1 : 1'($urandom);
            end else begin
                start = 1'b0;
            end
        end
        chk("latency", dk, W);
        chk("busy_cycles", bc, W);
        chk("done_pulses", dn, 1);
        chk("held", 32'(result), 32'(e[W-1:0]));
    endtask

    task automatic reset_mid_op();
        int dn;
        @(negedge clk);
        op_a  = 8'h5A;
        op_b  = 8'h3C;
        mc    = 2'b00;
        mux   = 4'hF;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 4; k++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_flags", 32'({cout, zero, ovf}), 0);
        chk("rst_slice", 32'({slice_a, slice_b, slice_cin,
                              slice_mc, slice_mux}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk("rst_no_done", dn, 0);
        chk("rst_idle", 32'(busy), 0);
    endtask

    task automatic back_to_back();
        logic [W-1:0] oa [3];
        logic [W-1:0] ob [3];
        logic [W+1:0] e  [3];
        oa[0] = 8'h12; ob[0] = 8'h34;
        oa[1] = 8'hF0; ob[1] = 8'h0F;
        oa[2] = 8'h80; ob[2] = 8'h80;
        for (int n = 0; n < 3; n++)
            e[n] = ref_op(oa[n], ob[n], 2'b00, 4'hF, 1'b0);
        @(negedge clk);
        op_a  = oa[0];
        op_b  = ob[0];
        mc    = 2'b00;
        mux   = 4'hF;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        for (int n = 0; n < 3; n++) begin
            for (int k = (n == 0) ? 0 : 1; k < W; k++)
                @(negedge clk);
            @(negedge clk);
            chk("b2b_done", 32'(done), 1);
            chk("b2b_result", 32'(result), 32'(e[n][W-1:0]));
            chk("b2b_cout", 32'(cout), 32'(e[n][W]));
            if (n < 2) begin
                op_a = oa[n+1];
                op_b = ob[n+1];
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            chk("b2b_idle", 32'(busy), 0);
            chk("b2b_hold", 32'(result), 32'(e[n][W-1:0]));
            if (n < 2) begin
                @(negedge clk);
                chk("b2b_accept", 32'(busy), 1);
                chk("b2b_hold2", 32'(result), 32'(e[n][W-1:0]));
            end
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1;
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_result", 32'(result), 0);
        chk("reset_flags", 32'({cout, zero, ovf}), 0);
        chk("reset_slice", 32'({slice_a, slice_b, slice_cin,
                                slice_mc, slice_mux}), 0);
        #20 rst_n = 1'b1;

        run_op(8'h5A, 8'h3C, 2'b00, 4'hF, 1'b0);
        run_op(8'hFF, 8'h01, 2'b00, 4'hF, 1'b0);
        run_op(8'h7F, 8'h01, 2'b00, 4'hF, 1'b0);
        run_op(8'hF0, 8'hCC, 2'b11, 4'h8, 1'b0);
        run_op(8'h0F, 8'h00, 2'b10, 4'h0, 1'b1);
        run_op(8'h80, 8'h80, 2'b00, 4'hF, 1'b1);
        run_op(8'h7F, 8'h00, 2'b01, 4'h3, 1'b1);

        reset_mid_op();
        run_op(8'h5A, 8'h3C, 2'b00, 4'hF, 1'b0);

        for (int i = 0; i < 24; i++)
            run_op(W'($urandom), W'($urandom), 2'($urandom),
                   4'($urandom), 1'($urandom));

        back_to_back();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
